// File: rtl/interp_pkg.sv
// Shared constants and FSM state type for the interpolator line feeder.
package interp_pkg;

  localparam int LINE_LEN  = 16;
  localparam int NUM_LINES = 16;
  localparam int PRE_PAD   = 8;
  localparam int POST_PAD  = 5;
  localparam int SUB_LAT   = 5;

  localparam int CYC_W  = 5;
  localparam int LINE_W = 4;
  localparam int POS_W  = 4;

  // A read issued on line cycle c shows up on pix_out at cycle c+2
  // (one cycle of memory latency, one cycle of output register).
  localparam int RD_LEAD = 2;

  // Line-cycle landmarks (cycle 0 is the first PRE cycle).
  localparam logic [CYC_W-1:0] C_PRE_LAST  = CYC_W'(PRE_PAD - 1);
  localparam logic [CYC_W-1:0] C_BODY_LAST = CYC_W'(PRE_PAD + LINE_LEN - 1);
  localparam logic [CYC_W-1:0] C_LAST      = CYC_W'(PRE_PAD + LINE_LEN + POST_PAD - 1);
  localparam logic [CYC_W-1:0] C_RD_FIRST  = CYC_W'(PRE_PAD - RD_LEAD);
  localparam logic [CYC_W-1:0] C_RD_LAST   = CYC_W'(PRE_PAD - RD_LEAD + LINE_LEN - 1);
  localparam logic [CYC_W-1:0] C_CAP_FIRST = CYC_W'(PRE_PAD - RD_LEAD + 1);
  localparam logic [CYC_W-1:0] C_CAP_LAST  = CYC_W'(PRE_PAD - RD_LEAD + LINE_LEN);
  localparam logic [CYC_W-1:0] C_SUB_FIRST = CYC_W'(PRE_PAD + SUB_LAT);
  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    WAIT0,
    PRE,
    BODY,
    POST,
    DONE
  } state_t;

endpackage

// File: rtl/interp_addr_gen.sv
// Pixel word address for a 16x16 block: rows are contiguous 16-word runs,
// so a column pass just swaps which index is scaled by 16. Wraps mod 2^32.
module interp_addr_gen
  import interp_pkg::*;
(
  input  logic [31:0]       base,
  input  logic              mode,
  input  logic [LINE_W-1:0] line,
  input  logic [POS_W-1:0]  p,
  output logic [31:0]       address
);

  logic [3:0] w_major;
  logic [3:0] w_minor;

  assign w_major = mode ? p : line;
  assign w_minor = mode ? line : p;
  assign address = base + {24'd0, w_major, 4'd0} + {28'd0, w_minor};

endmodule

// File: rtl/interp_feeder.sv
// Feeds one 16-line pass of a block into the interpolator: each line is
// padded with 8 copies of its left edge and 5 copies of its right edge,
// and the sub-pel result window is flagged once the pipeline has filled.
module interp_feeder
  import interp_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [31:0]       base_addr,
  output logic              mem_rd,
  output logic [31:0]       mem_addr,
  input  logic [31:0]       mem_data,
  output logic [31:0]       pix_out,
  output logic              pix_valid,
  output logic              sub_valid,
  output logic [LINE_W-1:0] sub_line,
  output logic [POS_W-1:0]  sub_pos,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [CYC_W-1:0]  r_cyc;
  logic [LINE_W-1:0] r_line;
  logic              r_mode;
  logic [31:0]       r_base;
  logic [31:0]       r_edgeLeft;

  state_t            w_nextState;
  logic [CYC_W-1:0]  w_nextCyc;
  logic [LINE_W-1:0] w_nextLine;
  logic              w_nextMode;
  logic [31:0]       w_nextBase;
  logic              w_nextRd;
  logic [POS_W-1:0]  w_nextP;
  logic [31:0]       w_rdAddr;
  logic              w_capture;
  logic              w_inLine;

  // Next-state and line-cycle sequencing; mode/base only load on an accepted start.
  always_comb begin
    w_nextState = r_state;
    w_nextCyc   = r_cyc;
    w_nextLine  = r_line;
    w_nextMode  = r_mode;
    w_nextBase  = r_base;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = FETCH0;
          w_nextLine  = '0;
          w_nextMode  = mode;
          w_nextBase  = base_addr;
        end
      end
      FETCH0: w_nextState = WAIT0;
      WAIT0: begin
        w_nextState = PRE;
        w_nextCyc   = '0;
      end
      PRE: begin
        w_nextCyc = r_cyc + 1'b1;
        if (r_cyc == C_PRE_LAST) w_nextState = BODY;
      end
      BODY: begin
        w_nextCyc = r_cyc + 1'b1;
        if (r_cyc == C_BODY_LAST) w_nextState = POST;
      end
      POST: begin
        if (r_cyc == C_LAST) begin
          if (r_line == LAST_LINE) begin
            w_nextState = DONE;
          end else begin
            w_nextState = FETCH0;
            w_nextLine  = r_line + 1'b1;
          end
        end else begin
          w_nextCyc = r_cyc + 1'b1;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Decide whether next cycle issues a read and for which pixel; FETCH0 always reads p0.
  always_comb begin
    w_nextRd = 1'b0;
    w_nextP  = '0;
    if (w_nextState == FETCH0) begin
      w_nextRd = 1'b1;
    end else if ((w_nextState == PRE || w_nextState == BODY) &&
                 w_nextCyc >= C_RD_FIRST && w_nextCyc <= C_RD_LAST) begin
      w_nextRd = 1'b1;
      w_nextP  = POS_W'(w_nextCyc - C_RD_FIRST);
    end
  end

  assign w_capture = (r_state == PRE || r_state == BODY) &&
                     r_cyc >= C_CAP_FIRST && r_cyc <= C_CAP_LAST;
  assign w_inLine  = (w_nextState == PRE) || (w_nextState == BODY) || (w_nextState == POST);

  interp_addr_gen u_addrGen (
    .base    (w_nextBase),
    .mode    (w_nextMode),
    .line    (w_nextLine),
    .p       (w_nextP),
    .address (w_rdAddr)
  );

  // Pass FSM plus all registered outputs, each loaded from the next-state decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cyc      <= '0;
      r_line     <= '0;
      r_mode     <= 1'b0;
      r_base     <= '0;
      r_edgeLeft <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      pix_out    <= '0;
      pix_valid  <= 1'b0;
      sub_valid  <= 1'b0;
      sub_line   <= '0;
      sub_pos    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cyc   <= w_nextCyc;
      r_line  <= w_nextLine;
      r_mode  <= w_nextMode;
      r_base  <= w_nextBase;
      mem_rd  <= w_nextRd;
      if (w_nextRd) mem_addr <= w_rdAddr;
      if (r_state == WAIT0) begin
        r_edgeLeft <= mem_data;
        pix_out    <= mem_data;
      end else if (w_nextState == PRE) begin
        pix_out <= r_edgeLeft;
      end else if (w_capture) begin
        pix_out <= mem_data;
      end
      pix_valid <= w_inLine;
      sub_valid <= w_inLine && (w_nextCyc >= C_SUB_FIRST);
      if (w_inLine && (w_nextCyc >= C_SUB_FIRST)) begin
        sub_pos  <= POS_W'(w_nextCyc - C_SUB_FIRST);
        sub_line <= w_nextLine;
      end
      busy <= (w_nextState != IDLE);
      done <= (w_nextState == DONE);
    end
  end

endmodule

// File: doc/interp_feeder.md
INTERP_FEEDER -- requirements
Module: interp_feeder

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  in  1  one-cycle pulse that begins a 16-line pass; sampled only in IDLE.
REQ-004 SHALL have port: mode  in  1  0 = row pass, 1 = column pass; sampled with start.
REQ-005 SHALL have port: base_addr  in  32  word address of block pixel (0,0); sampled with start.
REQ-006 SHALL have port: mem_rd  out  1  read strobe to pixel memory.
REQ-007 SHALL have port: mem_addr  out  32  read word address.
REQ-008 SHALL have port: mem_data  in  32  read data, valid exactly 1 cycle after mem_rd.
REQ-009 SHALL have port: pix_out  out  32  registered pixel to the interpolator data_in.
REQ-010 SHALL have port: pix_valid  out  1  pix_out carries a pad or body pixel.
REQ-011 SHALL have port: sub_valid  out  1  interpolator a/b/c outputs are valid this cycle.
REQ-012 SHALL have port: sub_line  out  4  line index of the current sub-pel result.
REQ-013 SHALL have port: sub_pos  out  4  position index of the current sub-pel result.
REQ-014 SHALL have port: busy  out  1  high from start acceptance until done.
REQ-015 SHALL have port: done  out  1  one-cycle pulse at pass end.

Function
REQ-016 FSM states SHALL be IDLE, FETCH0, WAIT0, PRE, BODY, POST, DONE.
REQ-017 Per line, SHALL run FETCH0 (1 cycle) -> WAIT0 (1) -> PRE (8) -> BODY (16) -> POST (5), 31 cycles total.
REQ-018 Line cycle numbering: first PRE cycle = 0, cycles 0..28.
REQ-019 Pixel address SHALL be base_addr + 16*line + p in row mode and base_addr + 16*p + line in column mode, mod 2^32.
REQ-020 FETCH0 SHALL assert mem_rd for p=0; the returned word SHALL be held as the line's edge-left value.
REQ-021 mem_rd for pixel p SHALL be asserted at line cycle 6+p, p=0..15; no other reads SHALL occur.
REQ-022 pix_out SHALL be p0 on cycles 0..7, pixel p on cycle 8+p, and pixel 15 on cycles 24..28.
REQ-023 pix_valid SHALL be high on cycles 0..28 only.
REQ-024 sub_valid SHALL be high on cycles 13..28, with sub_pos = cycle-13 and sub_line = current line.
REQ-025 After POST of line 15, FSM SHALL enter DONE for one cycle, pulse done, then return to IDLE.
REQ-026 After POST of lines 0..14, FSM SHALL enter FETCH0 of the next line.
REQ-027 busy SHALL be high in every state except IDLE; a full pass SHALL take 16*31 + 1 = 497 cycles from start acceptance to done.
REQ-028 start SHALL be ignored while busy; mode and base_addr SHALL be latched and stay stable for the whole pass.
REQ-029 When mem_rd is low, mem_addr SHALL hold its last value.

Reset
REQ-030 On reset_n low, the FSM SHALL go to IDLE immediately, including mid-pass, abandoning the pass without a done pulse.
REQ-031 Reset values SHALL be: mem_rd=0, mem_addr=0, pix_out=0, pix_valid=0, sub_valid=0, sub_line=0, sub_pos=0, busy=0, done=0.

Structure
REQ-032 Package interp_pkg SHALL hold LINE_LEN=16, NUM_LINES=16, PRE_PAD=8, POST_PAD=5, SUB_LAT=5, and the FSM state enum.
REQ-033 Address generation (REQ-019) SHALL be a sub-module interp_addr_gen (inputs base, mode, line, p; output address).

Verification
REQ-034 Row pass: mem[base+i] = i, base = 0x100, mode = 0 -> line 0 pix_out is 0 x8, then 0..15, then 15 x5; sub_valid sub_pos 0..15 on cycles 13..28.
REQ-035 Column pass: mode = 1, base = 0x100, line 1 -> mem_addr sequence 0x101, 0x111, ..., 0x1F1; pix_out body is 1, 17, ..., 241.
REQ-036 Timing: start at cycle T -> done high exactly at T+497, busy low at T+498; 16*17 = 272 mem_rd pulses total.
REQ-037 Wrap: base = 0xFFFF_FFF0, mode = 0 -> line 1 p 0 address is 0x0000_0000.
REQ-038 Reset mid-pass: assert reset_n=0 during line 7 BODY -> all outputs go to reset values at once, no done pulse; the next start runs a full correct pass.
REQ-039 start pulsed during busy with different mode/base -> ignored; pass addresses are unchanged.
